// File: rtl/mult_share_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter slice.
package mult_share_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned LATENCY_DEF = 3;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

    localparam int unsigned TAG_W  = clog2_f(NUM_REQ_DEF);
    localparam int unsigned PROD_W = 2 * DATA_W_DEF;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Issue/response bundle between the requesters and the shared multiplier.
interface mult_share_arbiter_if #(
    parameter int unsigned NUM_REQ = mult_share_pkg::NUM_REQ_DEF,
    parameter int unsigned DATA_W  = mult_share_pkg::DATA_W_DEF
);
    localparam int unsigned IDW = mult_share_pkg::clog2_f(NUM_REQ);

    logic                      pipe_stall;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [IDW-1:0]            rsp_id;
    logic [2*DATA_W-1:0]       rsp_data;
    logic                      busy;

    modport master (
        output pipe_stall, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  pipe_stall, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/rr_grant_picker.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit, rotate back.
module rr_grant_picker
    import mult_share_pkg::*;
#(
    parameter  int unsigned N   = NUM_REQ_DEF,
    localparam int unsigned IDW = clog2_f(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);
    localparam int unsigned SW = IDW + 1;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] pri_idx;
    logic [SW-1:0]  sum;

    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: N];
        pri_idx = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_rot[k]) pri_idx = IDW'(k);
        end
        // Offset back into the unrotated index space, modulo N.
        sum = SW'(ptr) + SW'(pri_idx);
        if (sum >= SW'(N)) sum = sum - SW'(N);
        gnt_id = IDW'(sum);
        any    = en && (|req);
        gnt    = any ? (N'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one tagged, pipelined unsigned multiplier among NUM_REQ requesters.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LATENCY = LATENCY_DEF
) (
    input  logic          clockPulse,
    input  logic          resetPulse,
    mult_share_arbiter_if.slave bus
);
    localparam int unsigned IDW = clog2_f(NUM_REQ);
    localparam int unsigned PW  = 2 * DATA_W;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_any;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;

    logic [IDW-1:0]     rr_ptr_q,   rr_ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [IDW-1:0]     s1_tag_q,   s1_tag_d;
    logic [DATA_W-1:0]  s1_a_q,     s1_a_d;
    logic [DATA_W-1:0]  s1_b_q,     s1_b_d;
    logic               st_valid_q [2:LATENCY];
    logic               st_valid_d [2:LATENCY];
    logic [IDW-1:0]     st_tag_q   [2:LATENCY];
    logic [IDW-1:0]     st_tag_d   [2:LATENCY];
    logic [PW-1:0]      st_prod_q  [2:LATENCY];
    logic [PW-1:0]      st_prod_d  [2:LATENCY];
    logic               busy_q,     busy_d;

    rr_grant_picker #(.N(NUM_REQ)) u_picker (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .en     (!bus.pipe_stall),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    assign a_sel = bus.req_a[int'(gnt_id) * DATA_W +: DATA_W];
    assign b_sel = bus.req_b[int'(gnt_id) * DATA_W +: DATA_W];

    // Stall freezes every register; otherwise stage 1 takes the winner (or a bubble) and the rest shift.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        st_valid_d = st_valid_q;
        st_tag_d   = st_tag_q;
        st_prod_d  = st_prod_q;

        if (!bus.pipe_stall) begin
            s1_valid_d = gnt_any;
            if (gnt_any) begin
                s1_tag_d = gnt_id;
                s1_a_d   = a_sel;
                s1_b_d   = b_sel;
                rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            end
            st_valid_d[2] = s1_valid_q;
            st_tag_d[2]   = s1_tag_q;
            st_prod_d[2]  = PW'(s1_a_q) * PW'(s1_b_q);
            for (int unsigned k = 3; k <= LATENCY; k++) begin
                st_valid_d[k] = st_valid_q[k-1];
                st_tag_d[k]   = st_tag_q[k-1];
                st_prod_d[k]  = st_prod_q[k-1];
            end
        end

        busy_d = s1_valid_d;
        for (int unsigned k = 2; k <= LATENCY; k++) begin
            busy_d = busy_d | st_valid_d[k];
        end
    end

    always_ff @(posedge clockPulse or posedge resetPulse) begin
        if (resetPulse) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            for (int unsigned k = 2; k <= LATENCY; k++) begin
                st_valid_q[k] <= 1'b0;
                st_tag_q[k]   <= '0;
                st_prod_q[k]  <= '0;
            end
            busy_q     <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            for (int unsigned k = 2; k <= LATENCY; k++) begin
                st_valid_q[k] <= st_valid_d[k];
                st_tag_q[k]   <= st_tag_d[k];
                st_prod_q[k]  <= st_prod_d[k];
            end
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = st_valid_q[LATENCY];
    assign bus.rsp_id    = st_tag_q[LATENCY];
    assign bus.rsp_data  = st_prod_q[LATENCY];
    assign bus.busy      = busy_q;

endmodule
